// File: rtl/conv_col_feeder.sv
`default_nettype none
// ============================================================================
// conv_col_feeder : raster pixel stream -> K_H-tall packed column vectors
// Rev 1.0
// ============================================================================
module conv_col_feeder #(
  parameter int IMG_H = 16,
  parameter int IMG_W = 15,
  parameter int K_H   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  output logic                     col_valid,
  input  logic                     col_ready,
  output logic [8*K_H-1:0]         col_data,
  output logic [$clog2(IMG_H)-1:0] band_idx,
  output logic [$clog2(IMG_W)-1:0] col_idx,
  output logic                     col_last,
  output logic                     busy,
  output logic                     done
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] C_ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [RW-1:0] C_ROW_FILL_LAST = RW'(K_H - 2);
  localparam logic [RW-1:0] C_BAND_OFS      = RW'(K_H - 1);
  localparam logic [CW-1:0] C_COL_LAST      = CW'(IMG_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q;
  logic [RW-1:0]       row_cnt_q;
  logic [CW-1:0]       col_cnt_q;
  logic [7:0]          lb_q [K_H-1][IMG_W];
  logic                col_valid_q;
  logic [8*K_H-1:0]    col_data_q;
  logic [8*K_H-1:0]    col_data_d;
  logic [RW-1:0]       band_idx_q;
  logic [CW-1:0]       col_idx_q;
  logic                col_last_q;
  logic                done_q;

  logic                accept;
  logic                col_hs;
  logic                at_row_end;

  // One-deep output register: a pixel is taken only if its column has a slot.
  assign in_ready   = (state_q == S_FILL) ||
                      ((state_q == S_STREAM) && (!col_valid_q || col_ready));
  assign accept     = in_valid && in_ready;
  assign col_hs     = col_valid_q && col_ready;
  assign at_row_end = (col_cnt_q == C_COL_LAST);

  // Column uses pre-shift buffer contents with the live pixel as the newest row.
  always_comb begin
    col_data_d = '0;
    for (int k = 0; k < K_H - 1; k++) begin
      col_data_d[8*k +: 8] = lb_q[k][col_cnt_q];
    end
    col_data_d[8*(K_H-1) +: 8] = in_data;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < K_H - 2; k++) begin
        lb_q[k][col_cnt_q] <= lb_q[k+1][col_cnt_q];
      end
      lb_q[K_H-2][col_cnt_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_cnt_q   <= '0;
      col_cnt_q   <= '0;
      col_valid_q <= 1'b0;
      col_data_q  <= '0;
      band_idx_q  <= '0;
      col_idx_q   <= '0;
      col_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (accept) begin
        if (at_row_end) begin
          col_cnt_q <= '0;
          row_cnt_q <= (row_cnt_q == C_ROW_LAST) ? '0 : row_cnt_q + RW'(1);
        end else begin
          col_cnt_q <= col_cnt_q + CW'(1);
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            state_q   <= S_FILL;
          end
        end
        S_FILL: begin
          if (accept && at_row_end && (row_cnt_q == C_ROW_FILL_LAST)) begin
            state_q <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (accept) begin
            col_valid_q <= 1'b1;
            col_data_q  <= col_data_d;
            band_idx_q  <= row_cnt_q - C_BAND_OFS;
            col_idx_q   <= col_cnt_q;
            col_last_q  <= at_row_end;
            if (at_row_end && (row_cnt_q == C_ROW_LAST)) begin
              state_q <= S_DRAIN;
            end
          end else if (col_hs) begin
            col_valid_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (col_hs) begin
            col_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign col_valid = col_valid_q;
  assign col_data  = col_data_q;
  assign band_idx  = band_idx_q;
  assign col_idx   = col_idx_q;
  assign col_last  = col_last_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_col_feeder.sv
`default_nettype none
// ============================================================================
// tb_conv_col_feeder : self-checking bench for conv_col_feeder
// Rev 1.0
// ============================================================================
module tb_conv_col_feeder;

  localparam int H  = 16;
  localparam int W  = 15;
  localparam int K  = 3;
  localparam int SH = 5;
  localparam int SW = 4;
  localparam int SK = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, start, in_valid, col_ready;
  logic [7:0]     in_data;
  logic           in_ready, col_valid, col_last, busy, done;
  logic [8*K-1:0] col_data;
  logic [3:0]     band_idx, col_idx;

  logic            s_start, s_in_valid, s_col_ready;
  logic [7:0]      s_in_data;
  logic            s_in_ready, s_col_valid, s_col_last, s_busy, s_done;
  logic [8*SK-1:0] s_col_data;
  logic [2:0]      s_band_idx;
  logic [1:0]      s_col_idx;

  conv_col_feeder #(.IMG_H(H), .IMG_W(W), .K_H(K)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data),
    .band_idx(band_idx), .col_idx(col_idx), .col_last(col_last), .busy(busy), .done(done)
  );

  conv_col_feeder #(.IMG_H(SH), .IMG_W(SW), .K_H(SK)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .col_valid(s_col_valid), .col_ready(s_col_ready), .col_data(s_col_data),
    .band_idx(s_band_idx), .col_idx(s_col_idx), .col_last(s_col_last), .busy(s_busy), .done(s_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [23:0] data;
    logic [3:0]  band;
    logic [3:0]  col;
    logic        last;
  } col_t;

  logic [7:0] img [H][W];
  col_t       exp_q[$];
  col_t       got_q[$];

  // Reference: every band of K consecutive rows, every column, oldest row in the low byte.
  function automatic void build_expected();
    col_t e;
    exp_q.delete();
    for (int b = 0; b <= H - K; b++) begin
      for (int c = 0; c < W; c++) begin
        e.data = '0;
        for (int k = 0; k < K; k++) e.data[8*k +: 8] = img[b+k][c];
        e.band = 4'(b);
        e.col  = 4'(c);
        e.last = (c == W - 1);
        exp_q.push_back(e);
      end
    end
  endfunction

  // mode 0: (r*15+c)&0xFF, mode 1: 255 minus that, mode 2: random pixels
  task automatic run_image(input int mode, input bit rnd_ready, input bit rnd_valid,
                           input int abort_at, input bit start_mid);
    int   p, cyc, last_hs, stalls;
    bit   seen_done, prev_stall, acc;
    col_t cur, prev;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (mode == 0)      img[r][c] = 8'((r * 15 + c) & 255);
        else if (mode == 1) img[r][c] = 8'(255 - ((r * 15 + c) & 255));
        else                img[r][c] = 8'($urandom_range(0, 255));
      end
    end
    build_expected();
    got_q.delete();

    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; col_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_after_start", 64'(busy), 64'(1));
    check("in_ready_after_start", 64'(in_ready), 64'(1));

    p = 0; cyc = 0; last_hs = -10; stalls = 0; seen_done = 1'b0; prev_stall = 1'b0;
    prev = '0;
    while (!seen_done && cyc < 3000) begin
      col_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (p < H * W) && (!rnd_valid || ($urandom_range(0, 3) != 0));
      in_data   = (p < H * W) ? img[p / W][p % W] : 8'h00;
      start     = start_mid && (p == 120);
      #1;
      cur.data = col_data; cur.band = band_idx; cur.col = col_idx; cur.last = col_last;
      if (prev_stall) check("stall_hold", 64'(cur), 64'(prev));
      if (col_valid && !col_ready) check("in_ready_low_when_stalled", 64'(in_ready), 64'(0));
      if (!rnd_ready && !rnd_valid && p < H * W && !in_ready) stalls++;
      if (done) begin
        seen_done = 1'b1;
        check("done_after_last_hs", 64'(cyc), 64'(last_hs + 1));
        check("busy_with_done", 64'(busy), 64'(1));
      end
      prev_stall = col_valid && !col_ready;
      prev       = cur;
      if (col_valid && col_ready) begin
        got_q.push_back(cur);
        last_hs = cyc;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) p++;
      cyc++;
      if (abort_at >= 0 && p == abort_at) begin
        start = 1'b0;
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    col_ready = 1'b1;
    #1;
    if (!seen_done) check("image_timeout", 64'(0), 64'(1));
    check("done_single_cycle", 64'(done), 64'(0));
    check("busy_after_done", 64'(busy), 64'(0));
    if (!rnd_ready && !rnd_valid) check("no_input_stall", 64'(stalls), 64'(0));
    check("column_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("column%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic run_small();
    int          p, cyc, fill_px;
    bit          first_seen, seen_done, acc;
    logic [23:0] sexp[$];
    logic [23:0] sgot[$];
    for (int b = 0; b <= SH - SK; b++) begin
      for (int c = 0; c < SW; c++) begin
        sexp.push_back({8'((b + 2) * SW + c), 8'((b + 1) * SW + c), 8'(b * SW + c)});
      end
    end
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    p = 0; cyc = 0; fill_px = -1; first_seen = 1'b0; seen_done = 1'b0;
    while (!seen_done && cyc < 200) begin
      s_in_valid  = (p < SH * SW);
      s_in_data   = 8'(p);
      s_col_ready = 1'b1;
      #1;
      if (s_col_valid && !first_seen) begin
        first_seen = 1'b1;
        fill_px    = p - 1;
      end
      if (s_col_valid && s_col_ready) sgot.push_back(s_col_data);
      if (s_done) seen_done = 1'b1;
      acc = s_in_valid && s_in_ready;
      @(posedge clk);
      if (acc) p++;
      cyc++;
      @(negedge clk);
    end
    s_in_valid = 1'b0;
    if (!seen_done) check("small_timeout", 64'(0), 64'(1));
    check("small_fill_pixels", 64'(fill_px), 64'(8));
    check("small_column_count", 64'(sgot.size()), 64'(12));
    for (int i = 0; i < sgot.size() && i < sexp.size(); i++) begin
      check($sformatf("small_column%0d", i), 64'(sgot[i]), 64'(sexp[i]));
    end
  endtask

  typedef struct {
    logic        rst, st, iv;
    logic        ir, bz, cv, dn;
    logic [23:0] cd;
  } vec_t;

  vec_t vt[6];

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; col_ready = 1'b1;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_data = 8'h00; s_col_ready = 1'b1;

    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0};
    vt[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0};
    vt[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};

    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      rst = vt[i].rst; start = vt[i].st; in_valid = vt[i].iv; in_data = 8'hAA;
      @(posedge clk);
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vt[i].ir));
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vt[i].bz));
      check($sformatf("vec%0d_col_valid", i), 64'(col_valid), 64'(vt[i].cv));
      check($sformatf("vec%0d_done", i), 64'(done), 64'(vt[i].dn));
      check($sformatf("vec%0d_col_data", i), 64'(col_data), 64'(vt[i].cd));
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;

    run_image(0, 1'b0, 1'b0, -1, 1'b0);
    check("first_column", 64'(got_q[0]), 64'({24'h1E0F00, 4'd0, 4'd0, 1'b0}));
    check("last_column", 64'(got_q[got_q.size()-1]), 64'({24'hEFE0D1, 4'd13, 4'd14, 1'b1}));

    run_image(0, 1'b1, 1'b0, -1, 1'b1);

    run_image(0, 1'b0, 1'b0, 100, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_col_valid", 64'(col_valid), 64'(0));
    check("rst_col_data", 64'(col_data), 64'(0));
    check("rst_band_idx", 64'(band_idx), 64'(0));
    check("rst_col_idx", 64'(col_idx), 64'(0));
    check("rst_col_last", 64'(col_last), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    rst = 1'b0;

    run_image(0, 1'b0, 1'b0, -1, 1'b0);
    run_image(1, 1'b0, 1'b0, -1, 1'b0);
    check("inverted_first_column", 64'(got_q[0].data), 64'(24'hE1F0FF));

    run_image(2, 1'b1, 1'b1, -1, 1'b0);

    run_small();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
